// File: rtl/cell_selftest_ctrl.sv
// BIST sequencer for the primitive cell bank: 8 vectors, golden compare, sticky results.
// Optional first-fail capture ports under `define FIRST_FAIL_CAPTURE_EN.
module cell_selftest_ctrl #(
  parameter int SETTLE = 1,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             stim_a,
  output logic             stim_b,
  output logic             stim_sel,
  input  logic [7:0]       cell_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       fail_mask,
  output logic [ERR_W-1:0] err_cnt
`ifdef FIRST_FAIL_CAPTURE_EN
  ,
  output logic             first_fail_valid,
  output logic [2:0]       first_fail_vec
`endif
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [3:0]       SET_C   = 4'(SETTLE);
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  logic [2:0] state;
  logic [2:0] v;
  logic [3:0] cnt;
  logic [7:0] gold;
  logic [7:0] m;
  logic       is_idle;
  logic       is_load;
  logic       is_settle;
  logic       is_check;
  logic       is_done;
  logic       launch;
  logic       va;
  logic       vb;
  logic       vs;

  assign va = v[0];
  assign vb = v[1];
  assign vs = v[2];

  // bit order matches cell_out: notq q mux not nand xor or and
  assign gold = {~va, va, (vs ? va : vb), ~va,
                 ~(va & vb), va ^ vb, va | vb, va & vb};
  assign m = cell_out ^ gold;

  assign is_idle   = (state == S_IDLE);
  assign is_load   = (state == S_LOAD);
  assign is_settle = (state == S_SETTLE);
  assign is_check  = (state == S_CHECK);
  assign is_done   = (state == S_DONE);

  // DONE shows done for one cycle before a new start is accepted
  assign launch = start & (is_idle | (is_done & done));

  assign pass = done & ~(|fail_mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      v         <= 3'd0;
      cnt       <= 4'd0;
      stim_a    <= 1'b0;
      stim_b    <= 1'b0;
      stim_sel  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fail_mask <= 8'h00;
      err_cnt   <= '0;
    end else begin
      unique case (1'b1)
        is_idle, is_done: begin
          if (is_done && !done) begin
            done <= 1'b1;
          end else if (launch) begin
            fail_mask <= 8'h00;
            err_cnt   <= '0;
            v         <= 3'd0;
            busy      <= 1'b1;
            done      <= 1'b0;
            state     <= S_LOAD;
          end
        end
        is_load: begin
          stim_a   <= va;
          stim_b   <= vb;
          stim_sel <= vs;
          cnt      <= SET_C;
          state    <= S_SETTLE;
        end
        is_settle: begin
          cnt <= cnt - 4'd1;
          if (cnt <= 4'd1) state <= S_CHECK;
        end
        is_check: begin
          fail_mask <= fail_mask | m;
          if ((|m) && (err_cnt != ERR_MAX))
            err_cnt <= err_cnt + 1'b1;
          if (v == 3'd7) begin
            busy  <= 1'b0;
            state <= S_DONE;
          end else begin
            v     <= v + 3'd1;
            state <= S_LOAD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef FIRST_FAIL_CAPTURE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_fail_valid <= 1'b0;
      first_fail_vec   <= 3'd0;
    end else if (launch && !(is_done && !done)) begin
      first_fail_valid <= 1'b0;
      first_fail_vec   <= 3'd0;
    end else if (is_check && (|m) && !first_fail_valid) begin
      first_fail_valid <= 1'b1;
      first_fail_vec   <= v;
    end
  end
`else
  // first-fail capture not built
`endif

endmodule

// File: tb/tb_cell_selftest_ctrl.sv
// Scoreboard bench for cell_selftest_ctrl with a behavioural cell bank.
// Second instance (ERR_W=2, inverted bank) exercises counter saturation.
module tb_cell_selftest_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start;
  logic       sa, sb, ss, busy, done, pass;
  logic [7:0] cout, mask;
  logic [7:0] err;
  logic       sa2, sb2, ss2, busy2, done2, pass2;
  logic [7:0] cout2, mask2;
  logic [1:0] err2;
`ifdef FIRST_FAIL_CAPTURE_EN
  logic       ffv, ffv2;
  logic [2:0] ffn, ffn2;
`endif

  int mode;
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int mask; int err; int pass; int ffval; int ffvec;
  } exp_t;
  exp_t exp_q[$];
  exp_t exp2_q[$];
  int   vlog[$];

  cell_selftest_ctrl #(.SETTLE(1), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .stim_a(sa), .stim_b(sb), .stim_sel(ss),
    .cell_out(cout), .busy(busy), .done(done),
    .pass(pass), .fail_mask(mask), .err_cnt(err)
`ifdef FIRST_FAIL_CAPTURE_EN
    , .first_fail_valid(ffv), .first_fail_vec(ffn)
`endif
  );

  cell_selftest_ctrl #(.SETTLE(1), .ERR_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .stim_a(sa2), .stim_b(sb2), .stim_sel(ss2),
    .cell_out(cout2), .busy(busy2), .done(done2),
    .pass(pass2), .fail_mask(mask2), .err_cnt(err2)
`ifdef FIRST_FAIL_CAPTURE_EN
    , .first_fail_valid(ffv2), .first_fail_vec(ffn2)
`endif
  );

  // cell bank model; mode 0 ideal, 1 and s-a-0, 2 mux swapped, 3 inverted
  function automatic logic [7:0] bank(
    input logic a, input logic b, input logic s,
    input logic q, input int md);
    logic [7:0] o;
    o[0] = a & b;
    o[1] = a | b;
    o[2] = a ^ b;
    o[3] = ~(a & b);
    o[4] = ~a;
    o[5] = s ? a : b;
    o[6] = q;
    o[7] = ~q;
    if (md == 1) o[0] = 1'b0;
    if (md == 2) o[5] = s ? b : a;
    if (md == 3) o = ~o;
    return o;
  endfunction

  logic q1, q2;
  always @(posedge clk) begin
    q1 <= sa;
    q2 <= sa2;
    cyc <= cyc + 1;
  end
  always_comb cout  = bank(sa, sb, ss, q1, mode);
  always_comb cout2 = bank(sa2, sb2, ss2, q2, 3);

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", nm, act, req);
    end
  endtask

  // monitor for the main instance
  logic busy_p = 1'b0, done_p = 1'b0;
  int   t0 = 0;
  always @(negedge clk) begin
    exp_t e;
    if (busy && !busy_p) begin
      t0 = cyc;
      vlog.delete();
    end
    if (busy && ((cyc - t0) % 3 == 1))
      vlog.push_back(int'({ss, sb, sa}));
    if (done && !done_p) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("fail_mask", int'(mask), e.mask);
        chk("err_cnt", int'(err), e.err);
        chk("pass", int'(pass), e.pass);
        chk("latency", cyc - t0, 25);
        chk("stim_hold", int'({ss, sb, sa}), 7);
        chk("busy_at_done", int'(busy), 0);
`ifdef FIRST_FAIL_CAPTURE_EN
        chk("ff_valid", int'(ffv), e.ffval);
        chk("ff_vec", int'(ffn), e.ffvec);
`endif
      end
    end
    busy_p = busy;
    done_p = done;
  end

  // monitor for the saturating instance
  logic done2_p = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (done2 && !done2_p) begin
      if (exp2_q.size() == 0) begin
        chk("unexpected_done2", 1, 0);
      end else begin
        e = exp2_q.pop_front();
        chk("sat_mask", int'(mask2), e.mask);
        chk("sat_err", int'(err2), e.err);
        chk("sat_pass", int'(pass2), e.pass);
`ifdef FIRST_FAIL_CAPTURE_EN
        chk("sat_ff_valid", int'(ffv2), e.ffval);
        chk("sat_ff_vec", int'(ffn2), e.ffvec);
`endif
      end
    end
    done2_p = done2;
  end

  task automatic expect_run(input int mk, input int er,
                            input int ps, input int fv, input int fn);
    exp_t e;
    e.mask = mk; e.err = er; e.pass = ps;
    e.ffval = fv; e.ffvec = fn;
    exp_q.push_back(e);
    e.mask = 8'hFF; e.err = 3; e.pass = 0;
    e.ffval = 1; e.ffvec = 0;
    exp2_q.push_back(e);
  endtask

  task automatic pulse();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_done"}, int'(done), 0);
    chk({nm, "_pass"}, int'(pass), 0);
    chk({nm, "_mask"}, int'(mask), 0);
    chk({nm, "_err"}, int'(err), 0);
    chk({nm, "_stim"}, int'({ss, sb, sa}), 0);
    chk({nm, "_busy2"}, int'(busy2), 0);
`ifdef FIRST_FAIL_CAPTURE_EN
    chk({nm, "_ffv"}, int'(ffv), 0);
    chk({nm, "_ffn"}, int'(ffn), 0);
`endif
  endtask

  initial begin
    int dcnt;
    rst_n = 1'b0;
    start = 1'b0;
    mode  = 0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    // ideal bank, vector order 0..7
    expect_run(8'h00, 0, 1, 0, 0);
    pulse();
    wait_done();
    chk("vec_count", vlog.size(), 8);
    for (int i = 0; i < vlog.size(); i++)
      chk($sformatf("vec%0d", i), vlog[i], i);

    // and stuck-at-0
    mode = 1;
    expect_run(8'h01, 2, 0, 1, 3);
    pulse();
    wait_done();

    // mux inputs swapped
    mode = 2;
    expect_run(8'h20, 4, 0, 1, 1);
    pulse();
    wait_done();

    // reset during CHECK of v=3
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (11) @(posedge clk);
    #1 chk("mask_pre_rst", int'(mask), 8'h20);
    rst_n = 1'b0;
    #1 chk_zero("midrun_rst");
    @(negedge clk);
    rst_n = 1'b1;
    mode = 0;
    expect_run(8'h00, 0, 1, 0, 0);
    pulse();
    wait_done();

    // start held high: back-to-back runs
    for (int i = 0; i < 3; i++) expect_run(8'h00, 0, 1, 0, 0);
    dcnt = 0;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    start = 1'b0;
    chk("held_done_cycles", dcnt, 2);
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (2) @(negedge clk);
    chk("exp_q_left", exp_q.size(), 0);
    chk("exp2_q_left", exp2_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
